// File: rtl/dprintf_char_writer_if.sv
// dprintf request channel: requester holds valid/address/data until it samples ack.
interface dprintf_char_writer_if;
  logic        valid;
  logic [15:0] address;
  logic [63:0] data_0;
  logic [63:0] data_1;
  logic [63:0] data_2;
  logic [63:0] data_3;
  logic        ack;

  modport master (
    output valid,
    output address,
    output data_0,
    output data_1,
    output data_2,
    output data_3,
    input  ack
  );

  modport slave (
    input  valid,
    input  address,
    input  data_0,
    input  data_1,
    input  data_2,
    input  data_3,
    output ack
  );
endinterface

// File: rtl/dprintf_char_writer.sv
// Expands a captured 32-byte dprintf request into display SRAM character writes.
// Optional build macro DPRINTF_CHAR_WRITER_ZERO_SUPPRESS_EN enables 0xC0-0xCF zero-suppressed hex fields.
module dprintf_char_writer (
  input  logic                        clk,
  input  logic                        clk__enable,
  input  logic                        reset_n,
  dprintf_char_writer_if.slave        dprintf_req,
  output logic                        display_sram_write__enable,
  output logic [15:0]                 display_sram_write__address,
  output logic [7:0]                  display_sram_write__data,
  output logic                        busy
);

  typedef enum logic [0:0] {
    IDLE,
    EXPAND
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  bytes_q [32];
  logic [7:0]  bytes_d [32];
  logic [4:0]  ptr_q, ptr_d;
  logic        nib_lo_q, nib_lo_d;
  logic [4:0]  hex_cnt_q, hex_cnt_d;
  logic        zs_q, zs_d;
  logic        seen_q, seen_d;
  logic [15:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        we_q, we_d;
  logic [15:0] wa_q, wa_d;
  logic [7:0]  wd_q, wd_d;

  logic [255:0] req_flat;
  logic [7:0]   cur_byte;
  logic [3:0]   nib;
  logic [7:0]   digit_char;
  logic [5:0]   ptr_inc;
  logic         is_hex;
  logic         is_lit;
  logic         suppress;
  logic         advance;
  logic         finish;

  assign req_flat = {dprintf_req.data_0, dprintf_req.data_1,
                     dprintf_req.data_2, dprintf_req.data_3};
  assign cur_byte = bytes_q[ptr_q];
  assign nib      = nib_lo_q ? cur_byte[3:0] : cur_byte[7:4];
  assign ptr_inc  = {1'b0, ptr_q} + 6'd1;
  assign is_lit   = (cur_byte != 8'h00) && !cur_byte[7];

`ifdef DPRINTF_CHAR_WRITER_ZERO_SUPPRESS_EN
  assign is_hex = (cur_byte[7:4] == 4'h8) || (cur_byte[7:4] == 4'hC);
`else
  assign is_hex = (cur_byte[7:4] == 4'h8);
`endif

  // Leading zeros blank out only in suppress fields; the last digit is always real.
  assign suppress = zs_q && !seen_q && (nib == 4'h0) && (hex_cnt_q != 5'd1);

  always_comb begin
    if (suppress) begin
      digit_char = 8'h20;
    end else if (nib < 4'd10) begin
      digit_char = 8'h30 + {4'h0, nib};
    end else begin
      digit_char = 8'h57 + {4'h0, nib};
    end
  end

  always_comb begin
    state_d   = state_q;
    bytes_d   = bytes_q;
    ptr_d     = ptr_q;
    nib_lo_d  = nib_lo_q;
    hex_cnt_d = hex_cnt_q;
    zs_d      = zs_q;
    seen_d    = seen_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    advance   = 1'b0;
    finish    = 1'b0;

    if (clk__enable) begin
      case (state_q)
        IDLE: begin
          if (dprintf_req.valid && !ack_q) begin
            for (int unsigned i = 0; i < 32; i++) begin
              bytes_d[i] = req_flat[255 - 8*i -: 8];
            end
            addr_d    = dprintf_req.address;
            ptr_d     = 5'd0;
            nib_lo_d  = 1'b0;
            hex_cnt_d = 5'd0;
            zs_d      = 1'b0;
            seen_d    = 1'b0;
            ack_d     = 1'b1;
            busy_d    = 1'b1;
            state_d   = EXPAND;
          end
        end

        EXPAND: begin
          if (hex_cnt_q != 5'd0) begin
            we_d      = 1'b1;
            wa_d      = addr_q;
            wd_d      = digit_char;
            addr_d    = addr_q + 16'd1;
            hex_cnt_d = hex_cnt_q - 5'd1;
            if (nib != 4'h0) begin
              seen_d = 1'b1;
            end
            // A field ending on a high nibble drops the low nibble of that byte.
            if ((hex_cnt_q == 5'd1) || nib_lo_q) begin
              advance  = 1'b1;
              nib_lo_d = 1'b0;
            end else begin
              nib_lo_d = 1'b1;
            end
          end else if (cur_byte == 8'hFF) begin
            finish = 1'b1;
          end else if (is_lit) begin
            we_d    = 1'b1;
            wa_d    = addr_q;
            wd_d    = cur_byte;
            addr_d  = addr_q + 16'd1;
            advance = 1'b1;
          end else if (is_hex) begin
            hex_cnt_d = {1'b0, cur_byte[3:0]} + 5'd1;
            zs_d      = cur_byte[6];
            seen_d    = 1'b0;
            nib_lo_d  = 1'b0;
            advance   = 1'b1;
          end else begin
            advance = 1'b1;
          end

          if (advance) begin
            if (ptr_inc[5]) begin
              finish = 1'b1;
            end else begin
              ptr_d = ptr_inc[4:0];
            end
          end

          if (finish) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            hex_cnt_d = 5'd0;
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      for (int unsigned i = 0; i < 32; i++) begin
        bytes_q[i] <= '0;
      end
      ptr_q     <= '0;
      nib_lo_q  <= 1'b0;
      hex_cnt_q <= '0;
      zs_q      <= 1'b0;
      seen_q    <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bytes_q   <= bytes_d;
      ptr_q     <= ptr_d;
      nib_lo_q  <= nib_lo_d;
      hex_cnt_q <= hex_cnt_d;
      zs_q      <= zs_d;
      seen_q    <= seen_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
    end
  end

  assign dprintf_req.ack             = ack_q;
  assign display_sram_write__enable  = we_q;
  assign display_sram_write__address = wa_q;
  assign display_sram_write__data    = wd_q;
  assign busy                        = busy_q;

endmodule
